// File: rtl/dht_responder.sv
// DHT11/DHT22 single-wire sensor emulator: answers a host start pulse with the presence
// sequence and then 40 data bits {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first.
module dht_responder #(
    parameter int unsigned START_MIN = 1_800_000,
    parameter int unsigned RESP_DLY  = 2500,
    parameter int unsigned PRE_HIGH  = 1500,
    parameter int unsigned RESP_LOW  = 8000,
    parameter int unsigned RESP_HIGH = 8000,
    parameter int unsigned BIT_LOW   = 5000,
    parameter int unsigned BIT0_HIGH = 2650,
    parameter int unsigned BIT1_HIGH = 7000,
    parameter int unsigned END_HIGH  = 8000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_i,
    output logic       dht_o,
    output logic       dht_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [3:0] {
        StIdle, StStartLow, StWaitRel, StRespDly, StPreHi, StPreLo, StPreHi2,
        StBitLo, StBitHi, StEndLo, StEndHi
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;
    logic [39:0] shreg_q, shreg_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        sync1_q, s;
    logic        oe_d, o_d, busy_d, done_d;
    logic [9:0]  sum;

    assign sum = 10'(hum_int) + 10'(hum_dec) + 10'(tmp_int) + 10'(tmp_dec);

    always_comb begin
        state_d   = state_q;
        tmr_d     = (tmr_q != 32'd0) ? tmr_q - 32'd1 : 32'd0;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            // The IDLE sample is the first low sample, so START_LOW counts the rest.
            StIdle: if (!s) begin
                state_d = StStartLow;
                tmr_d   = START_MIN - 32'd2;
            end
            StStartLow: begin
                if (s) state_d = StIdle;
                else if (tmr_q == 32'd0) state_d = StWaitRel;
            end
            // The detection cycle is the first cycle of the response delay.
            StWaitRel: if (s) begin
                shreg_d   = {hum_int, hum_dec, tmp_int, tmp_dec, sum[7:0]};
                bit_cnt_d = 6'd0;
                state_d   = StRespDly;
                tmr_d     = RESP_DLY - 32'd2;
            end
            StRespDly: if (tmr_q == 32'd0) begin
                state_d = StPreHi;
                tmr_d   = PRE_HIGH - 32'd1;
            end
            StPreHi: if (tmr_q == 32'd0) begin
                state_d = StPreLo;
                tmr_d   = RESP_LOW - 32'd1;
            end
            StPreLo: if (tmr_q == 32'd0) begin
                state_d = StPreHi2;
                tmr_d   = RESP_HIGH - 32'd1;
            end
            StPreHi2: if (tmr_q == 32'd0) begin
                state_d = StBitLo;
                tmr_d   = BIT_LOW - 32'd1;
            end
            StBitLo: if (tmr_q == 32'd0) begin
                state_d = StBitHi;
                tmr_d   = shreg_q[39] ? BIT1_HIGH - 32'd1 : BIT0_HIGH - 32'd1;
            end
            StBitHi: if (tmr_q == 32'd0) begin
                shreg_d   = {shreg_q[38:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 6'd1;
                state_d   = (bit_cnt_q == 6'd39) ? StEndLo : StBitLo;
                tmr_d     = BIT_LOW - 32'd1;
            end
            StEndLo: if (tmr_q == 32'd0) begin
                state_d = StEndHi;
                tmr_d   = END_HIGH - 32'd1;
            end
            StEndHi: if (tmr_q == 32'd0) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        oe_d   = !(state_d inside {StIdle, StStartLow, StWaitRel, StRespDly});
        o_d    = !(state_d inside {StPreLo, StBitLo, StEndLo});
        busy_d = !(state_d inside {StIdle, StStartLow});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            s          <= 1'b1;
            state_q    <= StIdle;
            tmr_q      <= 32'd0;
            shreg_q    <= 40'd0;
            bit_cnt_q  <= 6'd0;
            dht_oe     <= 1'b0;
            dht_o      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync1_q    <= dht_i;
            s          <= sync1_q;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            dht_oe     <= oe_d;
            dht_o      <= o_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_dht_responder.sv
// Bench for dht_responder: emulates the host on a pulled-up wired line and checks each frame
// as a list of (level, duration) segments derived from the protocol rules.
module tb_dht_responder;

    localparam int unsigned START_MIN = 20;
    localparam int unsigned RESP_DLY  = 10;
    localparam int unsigned PRE_HIGH  = 6;
    localparam int unsigned RESP_LOW  = 12;
    localparam int unsigned RESP_HIGH = 11;
    localparam int unsigned BIT_LOW   = 5;
    localparam int unsigned BIT0_HIGH = 3;
    localparam int unsigned BIT1_HIGH = 8;
    localparam int unsigned END_HIGH  = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic       dht_i, dht_o, dht_oe, busy, frame_done;
    logic [7:0] hum_int = 8'h0, hum_dec = 8'h0, tmp_int = 8'h0, tmp_dec = 8'h0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    typedef struct {
        logic [7:0]  a, b, c, d;
        logic [39:0] frame;
    } vec_t;

    assign dht_i = host_low ? 1'b0 : (dht_oe ? dht_o : 1'b1);

    always #5 clk = ~clk;

    dht_responder #(
        .START_MIN(START_MIN), .RESP_DLY(RESP_DLY), .PRE_HIGH(PRE_HIGH),
        .RESP_LOW(RESP_LOW), .RESP_HIGH(RESP_HIGH), .BIT_LOW(BIT_LOW),
        .BIT0_HIGH(BIT0_HIGH), .BIT1_HIGH(BIT1_HIGH), .END_HIGH(END_HIGH)
    ) dut (
        .clk(clk), .rst(rst), .dht_i(dht_i), .dht_o(dht_o), .dht_oe(dht_oe),
        .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d);
        int sum;
        sum = int'(a) + int'(b) + int'(c) + int'(d);
        return {a, b, c, d, 8'(sum % 256)};
    endfunction

    // Host start of low_len cycles, release, then capture and verify one full frame.
    task automatic run_frame(input logic [7:0] a, b, c, d, input int low_len,
                             input logic [39:0] exp_frame, input string tag);
        int          t, busy_at, rel, cyc, early_done, bad, n1, total;
        logic        lvl;
        int          len;
        seg_t        got[$];
        seg_t        exp_q[$];
        logic [39:0] dec;
        hum_int = a; hum_dec = b; tmp_int = c; tmp_dec = d;
        t = 0; busy_at = 0; rel = 0;
        host_low = 1'b1;
        for (int i = 0; i < low_len; i++) begin
            step(); t++;
            if (busy && busy_at == 0) busy_at = t;
        end
        host_low = 1'b0;
        while (!dht_oe && rel < int'(RESP_DLY) + 100) begin
            step(); rel++; t++;
            if (busy && busy_at == 0) busy_at = t;
        end
        check({tag, " busy_delay"}, 64'(busy_at), 64'(START_MIN + 2));
        check({tag, " drive_delay"}, 64'(rel), 64'(RESP_DLY + 2));
        check({tag, " busy_in_frame"}, 64'(busy), 64'd1);
        // Bytes seen after the latch point must not leak into the frame.
        hum_int = ~a; hum_dec = ~b; tmp_int = a ^ 8'h5a; tmp_dec = d + 8'd1;
        lvl = dht_o; len = 1; cyc = 0; early_done = 0;
        while (dht_oe && cyc < 3000) begin
            step(); cyc++;
            if (!dht_oe) break;
            if (frame_done) early_done++;
            if (dht_o == lvl) len++;
            else begin
                got.push_back('{lvl, len});
                lvl = dht_o; len = 1;
            end
        end
        got.push_back('{lvl, len});
        check({tag, " done_at_release"}, 64'(frame_done), 64'd1);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " early_done"}, 64'(early_done), 64'd0);
        step();
        check({tag, " done_pulse_width"}, 64'(frame_done), 64'd0);

        exp_q.push_back('{1'b1, int'(PRE_HIGH)});
        exp_q.push_back('{1'b0, int'(RESP_LOW)});
        exp_q.push_back('{1'b1, int'(RESP_HIGH)});
        for (int k = 39; k >= 0; k--) begin
            exp_q.push_back('{1'b0, int'(BIT_LOW)});
            exp_q.push_back('{1'b1, exp_frame[k] ? int'(BIT1_HIGH) : int'(BIT0_HIGH)});
        end
        exp_q.push_back('{1'b0, int'(BIT_LOW)});
        exp_q.push_back('{1'b1, int'(END_HIGH)});
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (got[i].lvl !== exp_q[i].lvl || got[i].len != exp_q[i].len) bad++;
        check({tag, " seg_count"}, 64'(got.size()), 64'(exp_q.size()));
        check({tag, " seg_errors"}, 64'(bad), 64'd0);

        dec = 40'd0;
        for (int k = 0; k < 40 && 4 + 2 * k < got.size(); k++)
            dec = {dec[38:0], got[4 + 2 * k].len > int'(BIT0_HIGH + BIT1_HIGH) / 2};
        check({tag, " frame"}, 64'(dec), 64'(exp_frame));

        n1 = $countones(exp_frame);
        total = 0;
        foreach (got[i]) total += got[i].len;
        check({tag, " frame_len"}, 64'(total), 64'(PRE_HIGH + RESP_LOW + RESP_HIGH
              + 40 * BIT_LOW + n1 * BIT1_HIGH + (40 - n1) * BIT0_HIGH + BIT_LOW + END_HIGH));
    endtask

    // A host low too short to qualify must produce no activity at all.
    task automatic glitch(input int low_len, input string tag);
        int seen_busy, seen_oe;
        seen_busy = 0; seen_oe = 0;
        host_low = 1'b1;
        for (int i = 0; i < low_len; i++) begin
            step();
            if (busy) seen_busy++;
            if (dht_oe) seen_oe++;
        end
        host_low = 1'b0;
        for (int i = 0; i < int'(RESP_DLY) + 40; i++) begin
            step();
            if (busy) seen_busy++;
            if (dht_oe) seen_oe++;
        end
        check({tag, " busy_cycles"}, 64'(seen_busy), 64'd0);
        check({tag, " oe_cycles"}, 64'(seen_oe), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        logic [7:0]  ra, rb, rc, rd;
        int          rises, cyc;
        logic        prev;

        vecs.push_back('{8'h37, 8'h00, 8'h19, 8'h05, 40'h3700190555});
        vecs.push_back('{8'hFF, 8'hFF, 8'h01, 8'h02, 40'hFFFF010201});
        vecs.push_back('{8'h00, 8'h00, 8'h00, 8'h00, 40'h0000000000});
        vecs.push_back('{8'h80, 8'h80, 8'h80, 8'h80, 40'h8080808000});
        vecs.push_back('{8'h01, 8'h02, 8'h03, 8'h04, 40'h010203040A});

        step(); step(); step();
        check("reset dht_oe", 64'(dht_oe), 64'd0);
        check("reset dht_o", 64'(dht_o), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();

        foreach (vecs[i])
            run_frame(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, START_MIN + 5,
                      vecs[i].frame, $sformatf("vec%0d", i));

        glitch(START_MIN - 1, "glitch_max");
        glitch(1, "glitch_one");
        run_frame(8'h12, 8'h34, 8'h56, 8'h78, START_MIN, model_frame(8'h12, 8'h34, 8'h56, 8'h78),
                  "min_start");
        run_frame(8'hA5, 8'h5A, 8'hC3, 8'h3C, START_MIN * 6,
                  model_frame(8'hA5, 8'h5A, 8'hC3, 8'h3C), "long_low");

        // Reset during the high phase of bit 20.
        hum_int = 8'h55; hum_dec = 8'hAA; tmp_int = 8'h0F; tmp_dec = 8'hF0;
        host_low = 1'b1;
        for (int i = 0; i < int'(START_MIN) + 3; i++) step();
        host_low = 1'b0;
        cyc = 0;
        while (!dht_oe && cyc < 200) begin step(); cyc++; end
        prev = dht_o; rises = 0;
        while (rises < 21 && cyc < 3000) begin
            step(); cyc++;
            if (dht_oe && dht_o && !prev) rises++;
            prev = dht_o;
        end
        check("rst_mid reached_bit20", 64'(rises), 64'd21);
        step();
        rst = 1'b1;
        step();
        check("rst_mid dht_oe", 64'(dht_oe), 64'd0);
        check("rst_mid busy", 64'(busy), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        run_frame(8'h37, 8'h00, 8'h19, 8'h05, START_MIN + 2, 40'h3700190555, "after_rst");

        // Back-to-back frames separated by a short idle gap.
        for (int i = 0; i < 30; i++) step();
        run_frame(8'h11, 8'h22, 8'h33, 8'h44, START_MIN + 1, 40'h11223344AA, "b2b_0");
        for (int i = 0; i < 30; i++) step();
        run_frame(8'hFE, 8'h01, 8'h80, 8'h7F, START_MIN + 1, 40'hFE01807FFE, "b2b_1");

        for (int n = 0; n < 12; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            if (n % 4 == 0) glitch(int'($urandom_range(1, START_MIN - 1)), $sformatf("rglitch%0d", n));
            for (int i = 0; i < int'($urandom_range(2, 40)); i++) step();
            run_frame(ra, rb, rc, rd, START_MIN + int'($urandom_range(0, 8)),
                      model_frame(ra, rb, rc, rd), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dht_responder.md
# dht_responder

Synthesizable single-wire DHT11/DHT22 sensor emulator: the responder end of the DHT host protocol. It detects a host start pulse on the shared line, replies with the presence sequence, then shifts out 40 bits: humidity, temperature and checksum. It goes in loopback FPGA builds and self-checking benches against the host controller (`TOP`), replacing the behavioural sensor model. All durations are in `clk` cycles, with defaults for a 100 MHz clock.

## Interface
- `START_MIN`, 1_800_000: consecutive low samples that qualify a host start (18 ms).
- `RESP_DLY`, 2500: delay from host release to responder taking the line (25 µs).
- `PRE_HIGH`, 1500: responder drives high before the presence low (15 µs).
- `RESP_LOW`, 8000: presence low (80 µs).
- `RESP_HIGH`, 8000: presence high (80 µs).
- `BIT_LOW`, 5000: low preamble before each bit and before the end marker (50 µs).
- `BIT0_HIGH`, 2650: high time for a 0 bit (26.5 µs).
- `BIT1_HIGH`, 7000: high time for a 1 bit (70 µs).
- `END_HIGH`, 8000: final high before release (80 µs).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `dht_i` in 1: line level from the pad (asynchronous).
- `dht_o` out 1: level driven when `dht_oe`=1.
- `dht_oe` out 1: drive enable; 0 releases the line (pull-up).
- `hum_int`, `hum_dec`, `tmp_int`, `tmp_dec` in 8 each: measurement bytes.
- `busy` out 1: high from start qualification until the line is released.
- `frame_done` out 1: one-cycle pulse on release after the end marker.

## Operation
- `dht_i` passes through a 2-flop synchronizer; all decisions use the synchronized value `s`.
- A single 32-bit down-counter `tmr` times every phase. A phase lasting N cycles holds its outputs for exactly N cycles.
- States and transitions:
  - IDLE: `oe`=0. When `s`=0, load the count and go to START_LOW.
  - START_LOW: count low samples. If `s`=1 before START_MIN samples, go back to IDLE (glitch rejected, no output). When START_MIN is reached, set `busy` and go to WAIT_REL.
  - WAIT_REL: `oe`=0. Wait for `s`=1. A low held indefinitely is legal; stay in WAIT_REL.
  - On the `s` rising edge, latch the four bytes into a 40-bit shift register {hum_int, hum_dec, tmp_int, tmp_dec, chk}, then go to RESP_DLY.
  - `chk` = (hum_int + hum_dec + tmp_int + tmp_dec) mod 256, computed with a 10-bit sum truncated to 8 bits.
  - RESP_DLY (`oe`=0) → PRE_HI (`oe`=1, `o`=1) → PRE_LO (`o`=0, RESP_LOW) → PRE_HI2 (`o`=1, RESP_HIGH) → BIT_LO.
  - BIT_LO: `o`=0 for BIT_LOW cycles, then BIT_HI.
  - BIT_HI: `o`=1 for BIT1_HIGH cycles if the MSB of the shift register is 1, else BIT0_HIGH. Then shift left and increment the bit counter (6-bit).
  - After bit 40 (counter = 39 at the end of BIT_HI), go to END_LO.
  - END_LO: `o`=0 for BIT_LOW cycles. END_HI: `o`=1 for END_HIGH cycles.
  - Then release: `oe`=0, `busy`=0, pulse `frame_done`, and return to IDLE.
- Bits are sent MSB first: `hum_int[7]` first, `chk[0]` last.
- Inputs are sampled only at the latch point. Changes during a frame do not affect the frame in flight.
- While `dht_oe`=1 the block ignores `s`; no collision detection.
- A new start is only recognised from IDLE.

## Timing
- Reset values: `dht_oe`=0, `dht_o`=1, `busy`=0, `frame_done`=0. State is IDLE, counters are 0 and the shift register is 0.
- Reset asserted mid-frame releases the line (`dht_oe`=0) on the first `clk` edge with `rst`=1.
- `busy` rises 2 (sync) + START_MIN cycles after the pad falls.
- The responder drives the line RESP_DLY+2 cycles after the pad rises: the synchronizer adds 2 cycles to the RESP_DLY count.
- Frame duration from first drive: PRE_HIGH + RESP_LOW + RESP_HIGH + Σ per bit (BIT_LOW + BITx_HIGH) + BIT_LOW + END_HIGH.
- With defaults: 17500 + 40×7650 + n1×4350 + 13000 cycles, where n1 is the number of 1 bits.
- All outputs are registered, with no combinational path from `dht_i`.

## Test plan
1. Host holds the line low 18.5 ms, then releases; bytes 0x37,0x00,0x19,0x05 → after 2500+2 cycles, high 1500, low 8000, high 8000. Decoded frame is 0x3700190555 (`chk`=0x55), the end marker follows, and `frame_done` pulses once.
2. Bytes 0xFF,0xFF,0x01,0x02 → `chk`=0x01 (wrap-around). Every BIT_HI lasts 7000 or 2650 cycles exactly.
3. Host low pulse of START_MIN−1 cycles, then high → `busy` stays 0 and `dht_oe` stays 0 throughout.
4. Assert `rst` during BIT_HI of bit 20 → `dht_oe`=0 the next cycle. A later valid start produces a complete, correct frame.
5. Change the input bytes mid-frame → the transmitted frame still matches the bytes latched at release.
6. Two back-to-back host starts 1 ms after `frame_done` → two complete frames, each preceded by the full presence sequence.
